new_pc: RTL and testbench

//  Branch/jump target generator for the RV32I fetch stage.
//  - Combinationally computes the jump target: newpc = pc + immExt (branch/JAL), or (rs1 + immExt) & ~1 (JALR).
//  - Also computes the sequential pc+4.
//  - Provides a registered copy of the target for the fetch PC mux.

---
 rtl/rv32_pkg.sv | 10 +
 rtl/new_pc_adder.sv | 14 +
 rtl/new_pc.sv | 93 +++++++++
 tb/tb_new_pc.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv32_pkg.sv
// Shared RV32I datapath constants used by the fetch-stage target logic.
package rv32_pkg;

  localparam int unsigned XLEN = 32;
  localparam logic [31:0] RESET_ADDR_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] JALR_MASK = 32'hFFFF_FFFE;

  typedef logic [XLEN-1:0] xlen_t;

endpackage

// File: rtl/new_pc_adder.sv
// Plain modulo-2^Width adder; the carry out is intentionally dropped.
module new_pc_adder
  import rv32_pkg::*;
#(
  parameter int unsigned Width = XLEN
) (
  input  logic [Width-1:0] a_i,
  input  logic [Width-1:0] b_i,
  output logic [Width-1:0] sum_o
);

  assign sum_o = a_i + b_i;

endmodule

// File: rtl/new_pc.sv
// RV32I branch/jump target generator with a registered copy for the fetch PC mux.
// Optional misalignment flag enabled by defining NEWPC_MISALIGN_CHECK_EN.
module new_pc
  import rv32_pkg::*;
#(
  parameter int unsigned XLEN       = rv32_pkg::XLEN,
  parameter logic [31:0] RESET_ADDR = RESET_ADDR_DEFAULT
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] immExt,
  input  logic [XLEN-1:0] rs1,
  input  logic            jalr,
  input  logic            en,
  output logic [XLEN-1:0] newpc,
  output logic [XLEN-1:0] pc_plus4,
  output logic [XLEN-1:0] newpc_q,
  output logic            valid_q
`ifdef NEWPC_MISALIGN_CHECK_EN
  ,
  output logic            misaligned,
  output logic            misaligned_q
`endif
);

  logic [XLEN-1:0] base;
  logic [XLEN-1:0] target_sum;
  logic [XLEN-1:0] newpc_d;
  logic            valid_d;

  assign base = jalr ? rs1 : pc;

  new_pc_adder #(
    .Width(XLEN)
  ) u_target_adder (
    .a_i  (base),
    .b_i  (immExt),
    .sum_o(target_sum)
  );

  new_pc_adder #(
    .Width(XLEN)
  ) u_seq_adder (
    .a_i  (pc),
    .b_i  (XLEN'(4)),
    .sum_o(pc_plus4)
  );

  // JALR targets always have bit 0 cleared, regardless of the computed sum.
  assign newpc = jalr ? (target_sum & XLEN'(JALR_MASK)) : target_sum;

  always_comb begin
    newpc_d = newpc_q;
    valid_d = 1'b0;
    if (en) begin
      newpc_d = newpc;
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      newpc_q <= XLEN'(RESET_ADDR);
      valid_q <= 1'b0;
    end else begin
      newpc_q <= newpc_d;
      valid_q <= valid_d;
    end
  end

`ifdef NEWPC_MISALIGN_CHECK_EN
  logic misaligned_d;

  assign misaligned = (newpc[1:0] != 2'b00);

  always_comb begin
    misaligned_d = misaligned_q;
    if (en) begin
      misaligned_d = misaligned;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      misaligned_q <= 1'b0;
    end else begin
      misaligned_q <= misaligned_d;
    end
  end
`endif

endmodule

// File: tb/tb_new_pc.sv
// Self-checking bench for new_pc: directed vectors, random combinational and register checks.
module tb_new_pc;

  localparam logic [31:0] ResetAddr = 32'h0000_0000;

  logic        clk;
  logic        rst;
  logic [31:0] pc;
  logic [31:0] immExt;
  logic [31:0] rs1;
  logic        jalr;
  logic        en;
  logic [31:0] newpc;
  logic [31:0] pc_plus4;
  logic [31:0] newpc_q;
  logic        valid_q;
`ifdef NEWPC_MISALIGN_CHECK_EN
  logic        misaligned;
  logic        misaligned_q;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] exp_q;
  logic        exp_v;
`ifdef NEWPC_MISALIGN_CHECK_EN
  logic        exp_mis_q;
`endif

  new_pc #(
    .XLEN      (32),
    .RESET_ADDR(ResetAddr)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .pc      (pc),
    .immExt  (immExt),
    .rs1     (rs1),
    .jalr    (jalr),
    .en      (en),
    .newpc   (newpc),
    .pc_plus4(pc_plus4),
    .newpc_q (newpc_q),
    .valid_q (valid_q)
`ifdef NEWPC_MISALIGN_CHECK_EN
    ,
    .misaligned  (misaligned),
    .misaligned_q(misaligned_q)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: wide arithmetic reduced modulo 2^32, then JALR rounds down to even.
  function automatic logic [31:0] model_target(input logic [31:0] p, input logic [31:0] i,
                                               input logic [31:0] r, input logic j);
    logic [63:0] s;
    s = {32'b0, (j ? r : p)} + {32'b0, i};
    s = s % 64'h1_0000_0000;
    if (j) s = s - (s % 64'd2);
    return s[31:0];
  endfunction

  function automatic logic [31:0] model_plus4(input logic [31:0] p);
    logic [63:0] s;
    s = ({32'b0, p} + 64'd4) % 64'h1_0000_0000;
    return s[31:0];
  endfunction

  task automatic drive(input logic [31:0] p, input logic [31:0] i, input logic [31:0] r,
                       input logic j, input logic e);
    pc     = p;
    immExt = i;
    rs1    = r;
    jalr   = j;
    en     = e;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    drive(32'h1234_5678, 32'h10, 32'h0, 1'b0, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (newpc_q !== ResetAddr) begin
      n_fail++;
      $display("FAIL reset_newpc_q: got %h expected %h", newpc_q, ResetAddr);
    end
    n_checks++;
    if (valid_q !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_valid_q: got %b expected 0", valid_q);
    end
    n_checks++;
    if (newpc !== 32'h1234_5688) begin
      n_fail++;
      $display("FAIL reset_comb_newpc: got %h expected 12345688", newpc);
    end
`ifdef NEWPC_MISALIGN_CHECK_EN
    n_checks++;
    if (misaligned_q !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_misaligned_q: got %b expected 0", misaligned_q);
    end
`endif
    @(negedge clk);
    en  = 1'b0;
    rst = 1'b0;
    exp_q = ResetAddr;
    exp_v = 1'b0;
`ifdef NEWPC_MISALIGN_CHECK_EN
    exp_mis_q = 1'b0;
`endif
  endtask

  task automatic test_directed;
    logic [31:0] t_pc   [6];
    logic [31:0] t_imm  [6];
    logic [31:0] t_rs1  [6];
    logic        t_jalr [6];
    logic [31:0] t_exp  [6];
    logic [31:0] t_p4   [6];
    t_pc = '{32'h0, 32'hC, 32'hC, 32'hFFFF_FFFC, 32'h10, 32'h0};
    t_imm = '{32'h28, 32'h28, 32'hC, 32'h8, 32'hFFFF_FFF8, 32'h2};
    t_rs1 = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h101};
    t_jalr = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    t_exp = '{32'h28, 32'h34, 32'h18, 32'h4, 32'h8, 32'h102};
    t_p4 = '{32'h4, 32'h10, 32'h10, 32'h0, 32'h14, 32'h4};
    for (int k = 0; k < 6; k++) begin
      drive(t_pc[k], t_imm[k], t_rs1[k], t_jalr[k], 1'b0);
      #1;
      n_checks++;
      if (newpc !== t_exp[k]) begin
        n_fail++;
        $display("FAIL directed_newpc[%0d]: got %h expected %h", k, newpc, t_exp[k]);
      end
      n_checks++;
      if (pc_plus4 !== t_p4[k]) begin
        n_fail++;
        $display("FAIL directed_pc_plus4[%0d]: got %h expected %h", k, pc_plus4, t_p4[k]);
      end
    end
  endtask

  task automatic test_random_comb;
    logic [31:0] p, i, r, e;
    logic        j;
    for (int k = 0; k < 200; k++) begin
      p = $urandom;
      i = $urandom;
      r = $urandom;
      j = 1'($urandom_range(0, 1));
      if (k % 10 == 0) p = 32'hFFFF_FFFC + 32'($urandom_range(0, 3));
      drive(p, i, r, j, 1'b0);
      #1;
      e = model_target(p, i, r, j);
      n_checks++;
      if (newpc !== e) begin
        n_fail++;
        $display("FAIL rand_newpc: pc=%h imm=%h rs1=%h jalr=%b got %h expected %h",
                 p, i, r, j, newpc, e);
      end
      n_checks++;
      if (pc_plus4 !== model_plus4(p)) begin
        n_fail++;
        $display("FAIL rand_pc_plus4: pc=%h got %h expected %h", p, pc_plus4, model_plus4(p));
      end
`ifdef NEWPC_MISALIGN_CHECK_EN
      n_checks++;
      if (misaligned !== (e % 4 != 0)) begin
        n_fail++;
        $display("FAIL rand_misaligned: target=%h got %b", e, misaligned);
      end
`endif
    end
  endtask

  task automatic test_register;
    logic [31:0] p, i, r;
    logic        j, e;
    for (int k = 0; k < 150; k++) begin
      @(negedge clk);
      p = $urandom;
      i = $urandom;
      r = $urandom;
      j = 1'($urandom_range(0, 1));
      e = (k < 2) ? 1'b1 : 1'($urandom_range(0, 1));
      drive(p, i, r, j, e);
      @(posedge clk);
      if (e) begin
        exp_q = model_target(p, i, r, j);
`ifdef NEWPC_MISALIGN_CHECK_EN
        exp_mis_q = (exp_q % 4 != 0);
`endif
      end
      exp_v = e;
      #1;
      n_checks++;
      if (newpc_q !== exp_q) begin
        n_fail++;
        $display("FAIL reg_newpc_q[%0d]: en=%b got %h expected %h", k, e, newpc_q, exp_q);
      end
      n_checks++;
      if (valid_q !== exp_v) begin
        n_fail++;
        $display("FAIL reg_valid_q[%0d]: got %b expected %b", k, valid_q, exp_v);
      end
`ifdef NEWPC_MISALIGN_CHECK_EN
      n_checks++;
      if (misaligned_q !== exp_mis_q) begin
        n_fail++;
        $display("FAIL reg_misaligned_q[%0d]: got %b expected %b", k, misaligned_q, exp_mis_q);
      end
`endif
    end
  endtask

  task automatic test_reset_mid;
    @(negedge clk);
    drive(32'h0000_1000, 32'h0000_0040, 32'h0, 1'b0, 1'b1);
    @(posedge clk);
    #1;
    n_checks++;
    if (newpc_q !== 32'h0000_1040 || valid_q !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_capture: got %h/%b expected 00001040/1", newpc_q, valid_q);
    end
    #2;
    rst = 1'b1;
    #1;
    n_checks++;
    if (newpc_q !== ResetAddr || valid_q !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_async_reset: got %h/%b expected %h/0", newpc_q, valid_q, ResetAddr);
    end
    n_checks++;
    if (newpc !== 32'h0000_1040 || pc_plus4 !== 32'h0000_1004) begin
      n_fail++;
      $display("FAIL mid_comb_during_reset: got %h/%h expected 00001040/00001004",
               newpc, pc_plus4);
    end
    @(posedge clk);
    #1;
    n_checks++;
    if (newpc_q !== ResetAddr || valid_q !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_reset_overrides_en: got %h/%b expected %h/0", newpc_q, valid_q,
               ResetAddr);
    end
    @(negedge clk);
    rst = 1'b0;
    en  = 1'b0;
    @(posedge clk);
    #1;
    n_checks++;
    if (newpc_q !== ResetAddr || valid_q !== 1'b0) begin
      n_fail++;
      $display("FAIL post_reset_hold: got %h/%b expected %h/0", newpc_q, valid_q, ResetAddr);
    end
    @(negedge clk);
    en = 1'b1;
    @(posedge clk);
    #1;
    n_checks++;
    if (newpc_q !== 32'h0000_1040 || valid_q !== 1'b1) begin
      n_fail++;
      $display("FAIL post_reset_first_capture: got %h/%b expected 00001040/1", newpc_q, valid_q);
    end
    @(negedge clk);
    en = 1'b0;
  endtask

`ifdef NEWPC_MISALIGN_CHECK_EN
  task automatic test_misalign;
    drive(32'h0, 32'h6, 32'h0, 1'b0, 1'b0);
    #1;
    n_checks++;
    if (misaligned !== 1'b1) begin
      n_fail++;
      $display("FAIL misalign_imm6: got %b expected 1", misaligned);
    end
    immExt = 32'h8;
    #1;
    n_checks++;
    if (misaligned !== 1'b0) begin
      n_fail++;
      $display("FAIL misalign_imm8: got %b expected 0", misaligned);
    end
  endtask
`endif

  initial begin
    drive(32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
    rst = 1'b1;
    test_reset();
    test_directed();
    test_random_comb();
    test_register();
    test_reset_mid();
`ifdef NEWPC_MISALIGN_CHECK_EN
    test_misalign();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
